// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: decodes keypad scanner events and assembles a hex entry for the CPU
//   clk, rst              clock, asynchronous active-high reset
//   key_coord             {row,col} active-low one-hot scanner pulse, 8'h00 = no event
//   req_i / ack_i         CPU starts an entry / consumes the committed value
//   data_o / valid_o      committed value and its pending flag
//   busy_o, digit_cnt_o   entry in progress, digits currently held
//   timeout_o             one-cycle pulse when an idle entry is abandoned
//   disp_o                live accumulator echo, present only with KEYPAD_ECHO_EN
module keypad_entry_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DIGITS     = 8,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    localparam int CW            = $clog2(MAX_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            key_coord,
    input  logic                  req_i,
    input  logic                  ack_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic [CW-1:0]         digit_cnt_o,
    output logic                  timeout_o
`ifdef KEYPAD_ECHO_EN
    ,
    output logic [DATA_WIDTH-1:0] disp_o
`endif
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    // Key values indexed by {row,col}; slots 12 ('*') and 14 ('#') are unused.
    localparam logic [63:0] KEY_MAP = 64'hD000_C987_B654_A321;
    typedef enum logic [2:0] {IDLE = 3'b001, ENTRY = 3'b010, DONE = 3'b100} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] acc, acc_n, data_n;
    logic [CW-1:0] cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic valid_n, to_n;
    logic [2:0] r, c;
    logic [3:0] idx, digit;
    logic key_ok, is_star, is_hash;
    // {valid, index} of an active-low one-hot nibble
    function automatic logic [2:0] oh(input logic [3:0] n);
        return n == 4'b0111 ? 3'b100 : n == 4'b1011 ? 3'b101 :
               n == 4'b1101 ? 3'b110 : n == 4'b1110 ? 3'b111 : 3'b000;
    endfunction
    always_comb begin
        r       = oh(key_coord[7:4]);
        c       = oh(key_coord[3:0]);
        key_ok  = r[2] & c[2];
        idx     = {r[1:0], c[1:0]};
        digit   = KEY_MAP[idx*4 +: 4];
        is_star = idx == 4'd12;
        is_hash = idx == 4'd14;
    end
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = digit_cnt_o;
        timer_n = timer;
        data_n  = data_o;
        valid_n = valid_o;
        to_n    = 1'b0;
        if (state == IDLE) begin
            if (req_i) begin
                state_n = ENTRY;
                acc_n   = '0;
                cnt_n   = '0;
                timer_n = '0;
            end
        end else if (state == ENTRY) begin
            timer_n = key_ok ? '0 : timer + TW'(1);
            if (key_ok) begin
                if (is_hash) begin
                    if (digit_cnt_o != '0) begin
                        data_n  = acc;
                        valid_n = 1'b1;
                        state_n = DONE;
                    end
                end else if (is_star) begin
                    if (digit_cnt_o != '0) begin
                        acc_n = acc >> 4;
                        cnt_n = digit_cnt_o - CW'(1);
                    end
                end else if (digit_cnt_o < CW'(MAX_DIGITS)) begin
                    acc_n = {acc[DATA_WIDTH-5:0], digit};
                    cnt_n = digit_cnt_o + CW'(1);
                end
            end else if (TIMEOUT_CYCLES != 0 && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                // a key in this same cycle takes the branch above, so keys beat the timeout
                state_n = IDLE;
                to_n    = 1'b1;
                acc_n   = '0;
                cnt_n   = '0;
                timer_n = '0;
            end
        end else if (state == DONE) begin
            if (ack_i) begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        end else begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            digit_cnt_o <= '0;
            timer       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            digit_cnt_o <= cnt_n;
            timer       <= timer_n;
            data_o      <= data_n;
            valid_o     <= valid_n;
            busy_o      <= state_n == ENTRY;
            timeout_o   <= to_n;
        end
    end
`ifdef KEYPAD_ECHO_EN
    assign disp_o = acc;
`endif
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: scoreboard bench for keypad_entry_ctrl with a 16-cycle timeout
module tb_keypad_entry_ctrl;
    localparam logic [7:0] K1 = 8'h77, K2 = 8'h7B, K3 = 8'h7D, KA = 8'h7E;
    localparam logic [7:0] K4 = 8'hB7, K5 = 8'hBB, K6 = 8'hBD;
    localparam logic [7:0] K7 = 8'hD7, K8 = 8'hDB, K9 = 8'hDD;
    localparam logic [7:0] KS = 8'hE7, K0 = 8'hEB, KH = 8'hED;
    typedef struct {logic is_to; logic [31:0] data;} exp_t;
    exp_t q[$];
    logic clk = 1'b0, rst = 1'b1, req_i = 1'b0, ack_i = 1'b0;
    logic [7:0] key_coord = 8'h00;
    logic [31:0] data_o;
    logic valid_o, busy_o, timeout_o, vprev = 1'b0;
    logic [3:0] digit_cnt_o;
    int total = 0, bad = 0;
    keypad_entry_ctrl #(.DATA_WIDTH(32), .MAX_DIGITS(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .key_coord(key_coord), .req_i(req_i), .ack_i(ack_i),
        .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o),
        .digit_cnt_o(digit_cnt_o), .timeout_o(timeout_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press(input logic [7:0] k);
        @(negedge clk);
        key_coord = k;
        @(negedge clk);
        key_coord = 8'h00;
    endtask
    task automatic request();
        @(negedge clk);
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
    endtask
    task automatic acknowledge();
        @(negedge clk);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
    endtask
    task automatic expect_val(input logic [31:0] d);
        exp_t e;
        e.is_to = 1'b0;
        e.data  = d;
        q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (!rst && ((valid_o && !vprev) || timeout_o)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {31'd0, timeout_o}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_kind", {31'd0, timeout_o}, {31'd0, e.is_to});
                if (e.is_to) chk("to_valid", {31'd0, valid_o}, 32'd0);
                else chk("out_data", data_o, e.data);
            end
        end
        vprev <= valid_o;
    end
    initial begin
        int i;
        exp_t t;
        tick(2);
        rst = 1'b0;
        chk("rst_data", data_o, 32'd0);
        chk("rst_flags", {valid_o, busy_o, timeout_o}, 3'b000);
        chk("rst_cnt", {28'd0, digit_cnt_o}, 32'd0);
        press(K1);
        chk("idle_key_cnt", {28'd0, digit_cnt_o}, 32'd0);
        chk("idle_key_busy", {31'd0, busy_o}, 32'd0);
        request();
        chk("req_busy", {31'd0, busy_o}, 32'd1);
        expect_val(32'h1A0);
        press(K1); press(KA); press(K0);
        chk("t2_cnt", {28'd0, digit_cnt_o}, 32'd3);
        press(KH);
        chk("t2_valid", {31'd0, valid_o}, 32'd1);
        chk("t2_cnt_held", {28'd0, digit_cnt_o}, 32'd3);
        chk("t2_busy", {31'd0, busy_o}, 32'd0);
        acknowledge();
        chk("ack_valid", {31'd0, valid_o}, 32'd0);
        chk("ack_data_kept", data_o, 32'h1A0);
        request();
        press(KS);
        chk("star_empty", {28'd0, digit_cnt_o}, 32'd0);
        press(KH);
        chk("hash_empty", {30'd0, busy_o, valid_o}, 32'b10);
        press(8'h73);
        chk("bad_coord", {28'd0, digit_cnt_o}, 32'd0);
        press(K4); press(K5);
        chk("t3_cnt2", {28'd0, digit_cnt_o}, 32'd2);
        press(KS);
        chk("t3_bksp", {28'd0, digit_cnt_o}, 32'd1);
        press(K6);
        expect_val(32'h46);
        press(KH);
        acknowledge();
        request();
        press(K1); press(K2); press(K3); press(K4); press(K5);
        press(K6); press(K7); press(K8); press(K9);
        chk("t4_cnt_cap", {28'd0, digit_cnt_o}, 32'd8);
        expect_val(32'h12345678);
        press(KH);
        acknowledge();
        request();
        press(K3);
        t.is_to = 1'b1;
        t.data  = 32'd0;
        q.push_back(t);
        for (i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (timeout_o) break;
        end
        chk("to_cycles", i, 32'd16);
        chk("to_state", {valid_o, busy_o, digit_cnt_o}, 6'd0);
        tick(1);
        chk("to_pulse_once", {31'd0, timeout_o}, 32'd0);
        request();
        press(K3);
        tick(14);
        press(K5);
        chk("late_key_no_to", {31'd0, timeout_o}, 32'd0);
        chk("late_key_cnt", {27'd0, busy_o, digit_cnt_o}, {27'd0, 1'b1, 4'd2});
        expect_val(32'h35);
        press(KH);
        acknowledge();
        request();
        press(K7);
        expect_val(32'h7);
        press(KH);
        @(negedge clk);
        ack_i = 1'b1;
        req_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        req_i = 1'b0;
        chk("ackreq_state", {30'd0, valid_o, busy_o}, 32'd0);
        tick(1);
        chk("ackreq_req_dropped", {31'd0, busy_o}, 32'd0);
        request();
        press(K8);
        chk("pre_rst_cnt", {28'd0, digit_cnt_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst", {26'd0, valid_o, busy_o, digit_cnt_o}, 32'd0);
        chk("async_rst_data", data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
